comb_code_sender: RTL and testbench
===================================

COMB_CODE_SENDER -- requirements
Module: comb_code_sender

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: cycles each code is presented on num1/num2; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 4: WAIT cycles allowed for unlocked after each presentation; legal range 1..15.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request to begin a code attempt; honoured only in IDLE.
REQ-006 Port search  input  1  latched at start; 1 = sweep codes upward from the start code, 0 = single attempt.
REQ-007 Port code1_in  input  4  first digit of the start code; latched at start.
REQ-008 Port code2_in  input  4  second digit of the start code; latched at start.
REQ-009 Port unlocked  input  1  lock response; 1 = presented code accepted.
REQ-010 Port num1  output  4  first digit presented to the lock.
REQ-011 Port num2  output  4  second digit presented to the lock.
REQ-012 Port busy  output  1  high in DRIVE and WAIT.
REQ-013 Port done  output  1  one-cycle pulse in DONE.
REQ-014 Port found  output  1  last operation ended on unlocked; held until next accepted start.
REQ-015 Port found_code  output  8  {num1,num2} value that unlocked; valid when found=1, else 0.
REQ-016 Port attempts  output  8  presentations in current/last operation; saturates at 255.

Function
REQ-017 FSM states SHALL be IDLE, DRIVE, WAIT, DONE; encoding is free.
REQ-018 IDLE: start=1 SHALL latch {code1_in,code2_in} as cur and first, latch search, clear found, found_code and attempts, and enter DRIVE next cycle.
REQ-019 start SHALL be ignored in DRIVE, WAIT and DONE; a start asserted during DONE SHALL NOT launch a new operation.
REQ-020 Entering DRIVE SHALL increment attempts (saturating at 255).
REQ-021 DRIVE SHALL drive num1=cur[7:4], num2=cur[3:0] for exactly HOLD_CYCLES cycles, then enter WAIT.
REQ-022 Outside DRIVE, num1 and num2 SHALL be 0.
REQ-023 unlocked SHALL be sampled only in WAIT; unlocked in DRIVE or IDLE SHALL be ignored.
REQ-024 WAIT with unlocked=1 SHALL enter DONE with found=1 and found_code=cur.
REQ-025 After TIMEOUT WAIT cycles without unlocked: latched search=0 SHALL enter DONE with found=0.
REQ-026 Same timeout with search=1: cur SHALL increment modulo 256 (0xFF wraps to 0x00, num2 carries into num1); if new cur equals first, enter DONE with found=0, else re-enter DRIVE.
REQ-027 unlocked=1 on the last WAIT cycle SHALL take priority over timeout.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 Latency: start sampled on edge k SHALL put the code on num1/num2 in cycles k+1..k+HOLD_CYCLES; WAIT occupies cycles k+HOLD_CYCLES+1 onward.
REQ-030 Full sweep (no unlock) SHALL make 256 presentations; attempts SHALL read 255.

Reset
REQ-031 rst=0 SHALL immediately force IDLE regardless of clk, with num1=0, num2=0, busy=0, done=0, found=0, found_code=0, attempts=0, cur=0.
REQ-032 rst deasserted mid-operation SHALL NOT resume the operation; the block waits in IDLE for a new start.

Verification
REQ-033 Single hit: search=0, code=0x12, unlocked=1 on first WAIT cycle -> num1=1,num2=2 for 2 cycles, done pulse, found=1, found_code=0x12, attempts=1.
REQ-034 Single miss: search=0, code=0x12, unlocked held 0 -> 4 WAIT cycles, done pulse, found=0, found_code=0x00, attempts=1.
REQ-035 Sweep hit: search=1, code=0x10, lock accepts only 0x12 -> presentations 0x10,0x11,0x12; found=1, found_code=0x12, attempts=3.
REQ-036 Wrap/exhaust: search=1, code=0xFE, unlocked never -> presents 0xFE,0xFF,0x00,...,0xFD; found=0, attempts=255.
REQ-037 Ignored inputs: start pulsed in DRIVE, WAIT and DONE, unlocked=1 during DRIVE -> no restart, attempts unchanged, unlock not registered.
REQ-038 Reset mid-WAIT: rst=0 asynchronously -> all outputs 0 same cycle; after release, block idles until next start.

Source files
------------

// File: rtl/comb_code_sender.sv
// rtl/comb_code_sender.sv - presents 2-digit codes to a lock, single attempt or upward sweep
module comb_code_sender #(
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       search,
    input  logic [3:0] code1_in,
    input  logic [3:0] code2_in,
    input  logic       unlocked,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [7:0] found_code,
    output logic [7:0] attempts
);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cur;
    logic [7:0] first;
    logic [7:0] cur_inc;
    logic       search_q;
    logic [3:0] hold_cnt;
    logic [3:0] wait_cnt;
    logic       hold_last;
    logic       wait_last;
    logic       sweep_more;

    assign cur_inc    = cur + 8'd1;
    assign hold_last  = (hold_cnt == HOLD_LAST);
    assign wait_last  = (wait_cnt == WAIT_LAST);
    // The sweep ends once the next code would come back round to the start code
    assign sweep_more = search_q && (cur_inc != first);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = DRIVE;
            DRIVE: if (hold_last) state_nxt = WAIT;
            WAIT: begin
                if (unlocked) begin
                    state_nxt = DONE;
                end else if (wait_last) begin
                    state_nxt = sweep_more ? DRIVE : DONE;
                end
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign num1 = (state == DRIVE) ? cur[7:4] : 4'd0;
    assign num2 = (state == DRIVE) ? cur[3:0] : 4'd0;
    assign busy = (state == DRIVE) || (state == WAIT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cur        <= 8'd0;
            first      <= 8'd0;
            search_q   <= 1'b0;
            hold_cnt   <= 4'd0;
            wait_cnt   <= 4'd0;
            found      <= 1'b0;
            found_code <= 8'd0;
            attempts   <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur        <= {code1_in, code2_in};
                        first      <= {code1_in, code2_in};
                        search_q   <= search;
                        found      <= 1'b0;
                        found_code <= 8'd0;
                        attempts   <= 8'd1;
                        hold_cnt   <= 4'd0;
                    end
                end
                DRIVE: begin
                    hold_cnt <= hold_last ? 4'd0 : hold_cnt + 4'd1;
                    wait_cnt <= 4'd0;
                end
                WAIT: begin
                    if (unlocked) begin
                        found      <= 1'b1;
                        found_code <= cur;
                    end else if (wait_last) begin
                        wait_cnt <= 4'd0;
                        if (sweep_more) begin
                            cur      <= cur_inc;
                            hold_cnt <= 4'd0;
                            attempts <= (attempts == 8'hFF) ? 8'hFF : attempts + 8'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comb_code_sender.sv
// tb/tb_comb_code_sender.sv - scoreboard bench for comb_code_sender with a behavioural lock model
module tb_comb_code_sender;

    localparam int H = 2;
    localparam int T = 4;
    localparam int P = H + T;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       search = 1'b0;
    logic [3:0] code1_in = 4'd0;
    logic [3:0] code2_in = 4'd0;
    logic       unlocked = 1'b0;
    logic [3:0] num1;
    logic [3:0] num2;
    logic       busy;
    logic       done;
    logic       found;
    logic [7:0] found_code;
    logic [7:0] attempts;

    comb_code_sender #(.HOLD_CYCLES(H), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .start(start), .search(search),
        .code1_in(code1_in), .code2_in(code2_in), .unlocked(unlocked),
        .num1(num1), .num2(num2), .busy(busy), .done(done),
        .found(found), .found_code(found_code), .attempts(attempts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        found;
        logic [7:0]  found_code;
        logic [7:0]  attempts;
        logic [15:0] busy_len;
    } res_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] exp_pres[$];
    res_t exp_res[$];
    logic       acc_en = 1'b0;
    logic [7:0] acc_code = 8'd0;
    int         acc_delay = 0;
    logic       noise = 1'b0;
    int         done_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor and lock: busy-run position tells DRIVE cycles from WAIT cycles
    initial begin
        int pos;
        int busy_run;
        logic prev_busy;
        logic [7:0] cur_exp;
        logic [7:0] last_code;
        res_t r;
        pos = 0; busy_run = 0; prev_busy = 1'b0; cur_exp = 8'd0; last_code = 8'd0;
        forever begin
            @(negedge clk);
            if (busy) begin
                if (!prev_busy) begin
                    pos = 0;
                    busy_run = 0;
                end else begin
                    pos = (pos + 1) % P;
                end
                busy_run++;
            end
            prev_busy = busy;
            if (busy && pos < H) begin
                if (pos == 0) begin
                    if (exp_pres.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_presentation: actual=%0h required=none", {num1, num2});
                        cur_exp = {num1, num2};
                    end else begin
                        cur_exp = exp_pres.pop_front();
                    end
                end
                check("presented_code", {num1, num2}, cur_exp);
                last_code = {num1, num2};
                unlocked = noise ? 1'($urandom % 2) : 1'b0;
            end else if (busy) begin
                unlocked = acc_en && (last_code == acc_code) && ((pos - H) == acc_delay);
            end else begin
                check("idle_num", {num1, num2}, 0);
                unlocked = noise ? 1'($urandom % 2) : 1'b0;
            end
            if (done) begin
                check("busy_in_done", busy, 0);
                if (exp_res.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: actual=1 required=0");
                end else begin
                    r = exp_res.pop_front();
                    check("found", found, r.found);
                    check("found_code", found_code, r.found_code);
                    check("attempts", attempts, r.attempts);
                    check("busy_len", busy_run, r.busy_len);
                end
                done_cnt++;
            end
        end
    end

    task automatic run_op(input logic [7:0] code, input logic srch, input logic en,
                          input logic [7:0] acode, input int delay, input logic nz);
        logic [7:0] c;
        int   n;
        logic hit;
        logic stop;
        res_t r;
        int   target;
        int   budget;
        c = code; n = 0; hit = 1'b0; stop = 1'b0;
        while (!stop) begin
            exp_pres.push_back(c);
            n++;
            if (en && c == acode) begin
                hit = 1'b1;
                stop = 1'b1;
            end else if (!srch) begin
                stop = 1'b1;
            end else begin
                c = c + 8'd1;
                if (c == code) stop = 1'b1;
            end
        end
        r.found      = hit;
        r.found_code = hit ? acode : 8'd0;
        r.attempts   = (n > 255) ? 8'd255 : 8'(n);
        r.busy_len   = 16'((n - 1) * P + H + (hit ? delay + 1 : T));
        exp_res.push_back(r);
        acc_en = en; acc_code = acode; acc_delay = delay; noise = nz;
        target = done_cnt + 1;
        @(negedge clk); #1;
        start = 1'b1; search = srch; {code1_in, code2_in} = code;
        @(negedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (done_cnt < target && budget < 256 * P + 20) begin
            if (nz) begin
                start = 1'($urandom % 2);
                search = 1'($urandom % 2);
                {code1_in, code2_in} = 8'($urandom);
            end
            @(negedge clk); #1;
            budget++;
        end
        if (done_cnt < target) begin
            n_cmp++; n_bad++;
            $display("FAIL op_timeout: actual=no_done required=done");
            exp_pres.delete();
            exp_res.delete();
        end else if (nz) begin
            start = 1'b1;
            @(negedge clk); #1;
        end
        start = 1'b0;
        noise = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] code;
        logic       srch;
        logic       en;
        logic [7:0] acode;
        repeat (3) @(negedge clk);
        check("rst_num", {num1, num2}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_found_code", found_code, 0);
        check("rst_attempts", attempts, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'h12, 1'b0, 1'b1, 8'h12, 0, 1'b0);
        run_op(8'h12, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        run_op(8'h10, 1'b1, 1'b1, 8'h12, 0, 1'b0);
        run_op(8'hFE, 1'b1, 1'b0, 8'h00, 0, 1'b0);
        run_op(8'h55, 1'b0, 1'b1, 8'h55, T - 1, 1'b0);
        run_op(8'h34, 1'b1, 1'b1, 8'h36, 2, 1'b1);
        check("found_held_idle", found, 1);

        // Abort an operation while it is waiting on the lock
        acc_en = 1'b0;
        exp_pres.push_back(8'h77);
        @(negedge clk); #1;
        start = 1'b1; search = 1'b1; {code1_in, code2_in} = 8'h77;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (H + 1) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_pres.delete();
        exp_res.delete();
        #1;
        check("abort_num", {num1, num2}, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_found", found, 0);
        check("abort_attempts", attempts, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("post_abort_busy", busy, 0);
        check("post_abort_attempts", attempts, 0);

        for (int i = 0; i < 25; i++) begin
            code = 8'($urandom);
            srch = 1'($urandom % 2);
            en   = ($urandom % 4) != 0;
            if (srch) acode = code + 8'($urandom_range(0, 6));
            else      acode = ($urandom % 2) ? code : code ^ 8'h01;
            run_op(code, srch, en, acode, int'($urandom_range(0, T - 1)), 1'($urandom % 2));
        end

        check("pres_queue_empty", exp_pres.size(), 0);
        check("res_queue_empty", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
